// File: rtl/dilation_3x3_if.sv
// Pixel stream bundle for dilation_3x3: raster input with its qualifiers, dilated output with its markers.
// The master modport drives the input side; the slave modport belongs to the filter.
interface dilation_3x3_if;
    logic iDATA;
    logic iDVAL;
    logic iSOF;
    logic oDATA;
    logic oDVAL;
    logic oSOF;
    logic oEOL;

    modport master (
        output iDATA, iDVAL, iSOF,
        input  oDATA, oDVAL, oSOF, oEOL
    );

    modport slave (
        input  iDATA, iDVAL, iSOF,
        output oDATA, oDVAL, oSOF, oEOL
    );
endinterface

// File: rtl/dilation_3x3.sv
// Streaming 3x3 binary dilation over a raster mask, one registered output pixel per completed window.
// Build option: define DILATION_CROSS_EN for the 5-tap plus element; the default is the full 3x3 square.
module dilation_3x3 #(
    parameter int IMG_W = 320,
    parameter int IMG_H = 240
) (
    input logic iclk,
    input logic irst,
    dilation_3x3_if.slave bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0] col;
    logic [CW-1:0] cur_col;
    logic [CW-1:0] nxt_col;
    logic [RW-1:0] row;
    logic [RW-1:0] cur_row;
    logic [RW-1:0] nxt_row;
    logic          primed;

    logic          lb1 [IMG_W];
    logic          lb2 [IMG_W];

    // Window columns: bit 2 = row-2, bit 1 = row-1, bit 0 = current row.
    logic [2:0]    w1;
    logic [2:0]    w2;
    logic [2:0]    ncol;
    logic [2:0]    top_mask;
    logic          left_ok;
    logic          emit;
    logic          dil;

    // An iSOF pixel, or the first pixel after reset, is always (0,0).
    always_comb begin
        cur_col = col;
        cur_row = row;
        if (bus.iSOF || !primed) begin
            cur_col = '0;
            cur_row = '0;
        end
    end

    always_comb begin
        nxt_col = cur_col + 1'b1;
        nxt_row = cur_row;
        if (cur_col == CW'(IMG_W - 1)) begin
            nxt_col = '0;
            if (cur_row == RW'(IMG_H - 1)) begin
                nxt_row = '0;
            end else begin
                nxt_row = cur_row + 1'b1;
            end
        end
    end

    assign ncol     = {lb2[cur_col], lb1[cur_col], bus.iDATA};
    assign emit     = bus.iDVAL && (cur_row != '0) && (cur_col != '0);
    // Row -1 and column -1 taps come from stale buffers or the previous line.
    assign top_mask = (cur_row == RW'(1)) ? 3'b011 : 3'b111;
    assign left_ok  = (cur_col != CW'(1));

`ifdef DILATION_CROSS_EN
    assign dil = w1[1] | (w1[2] & top_mask[2]) | w1[0] | ncol[1] | (w2[1] & left_ok);
`else
    assign dil = (|(ncol & top_mask)) | (|(w1 & top_mask)) | (left_ok & (|(w2 & top_mask)));
`endif

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            col       <= '0;
            row       <= '0;
            primed    <= 1'b0;
            w1        <= '0;
            w2        <= '0;
            bus.oDATA <= 1'b0;
            bus.oDVAL <= 1'b0;
            bus.oSOF  <= 1'b0;
            bus.oEOL  <= 1'b0;
        end else begin
            bus.oDVAL <= emit;
            if (bus.iDVAL) begin
                col    <= nxt_col;
                row    <= nxt_row;
                primed <= 1'b1;
                w2     <= w1;
                w1     <= ncol;
            end
            if (emit) begin
                bus.oDATA <= dil;
                bus.oSOF  <= (cur_row == RW'(1)) && (cur_col == CW'(1));
                bus.oEOL  <= (cur_col == CW'(IMG_W - 1));
            end
        end
    end

    always_ff @(posedge iclk) begin
        if (bus.iDVAL) begin
            lb2[cur_col] <= lb1[cur_col];
            lb1[cur_col] <= bus.iDATA;
        end
    end
endmodule

// File: tb/tb_dilation_3x3.sv
// Scoreboard bench for dilation_3x3 on an 8x6 image: the driver predicts each output, the monitor checks it.
module tb_dilation_3x3;
    localparam int W = 8;
    localparam int H = 6;
`ifdef DILATION_CROSS_EN
    localparam int ONES_A = 5;
    localparam int ONES_C = 3;
`else
    localparam int ONES_A = 9;
    localparam int ONES_C = 4;
`endif

    typedef struct {
        logic   d;
        logic   sof;
        logic   eol;
        longint cyc;
    } exp_t;

    logic   iclk = 1'b0;
    logic   irst;
    longint cyc = 0;
    int     tests = 0;
    int     fails = 0;

    exp_t   sb[$];
    logic   cap[$];
    int     n_out = 0;
    int     n_ones = 0;
    int     n_sof = 0;
    int     rst_cnt = 0;
    int     seen_rst = 0;
    logic   last_d = 1'b0;
    logic   last_s = 1'b0;
    logic   last_e = 1'b0;

    logic   img [H][W];
    int     mr = 0;
    int     mc = 0;
    bit     m_primed = 0;

    dilation_3x3_if bus();

    dilation_3x3 #(.IMG_W(W), .IMG_H(H)) dut (
        .iclk (iclk),
        .irst (irst),
        .bus  (bus)
    );

    always #5 iclk = ~iclk;
    always @(posedge iclk) cyc <= cyc + 1;

    always @(negedge iclk) begin
        if (bus.oDVAL) begin
            n_out++;
            n_ones += int'(bus.oDATA);
            n_sof  += int'(bus.oSOF);
            cap.push_back(bus.oDATA);
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_out: oDVAL=1 data=%0b at cyc %0d, required no output", bus.oDATA, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (bus.oDATA !== e.d || bus.oSOF !== e.sof || bus.oEOL !== e.eol || cyc != e.cyc) begin
                    fails++;
                    $display("FAIL out_pixel: got data=%0b sof=%0b eol=%0b cyc=%0d, required data=%0b sof=%0b eol=%0b cyc=%0d",
                             bus.oDATA, bus.oSOF, bus.oEOL, cyc, e.d, e.sof, e.eol, e.cyc);
                end
            end
            last_d = bus.oDATA;
            last_s = bus.oSOF;
            last_e = bus.oEOL;
        end else begin
            if (rst_cnt != seen_rst) begin
                seen_rst = rst_cnt;
                last_d = 1'b0;
                last_s = 1'b0;
                last_e = 1'b0;
            end
            tests++;
            if (bus.oDATA !== last_d || bus.oSOF !== last_s || bus.oEOL !== last_e) begin
                fails++;
                $display("FAIL hold: got data=%0b sof=%0b eol=%0b, required %0b %0b %0b at cyc %0d",
                         bus.oDATA, bus.oSOF, bus.oEOL, last_d, last_s, last_e, cyc);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    function automatic logic pix(input int pid, input int r, input int c);
        case (pid)
            0:       return (r == 2 && c == 3);
            1:       return 1'b1;
            2:       return (r == 0 && c == 0);
            default: return ((r * 3 + c * 5) % 7) < 3;
        endcase
    endfunction

    function automatic logic exp_px(input int r, input int c);
        logic o = 1'b0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
`ifdef DILATION_CROSS_EN
                if (dr != 0 && dc != 0) continue;
`endif
                if (r + dr >= 0 && c + dc >= 0) o |= img[r + dr][c + dc];
            end
        end
        return o;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge iclk);
            bus.iDVAL = 1'b0;
            bus.iSOF  = 1'b0;
        end
    endtask

    task automatic send_px(input logic d, input logic sof);
        int r;
        int c;
        exp_t e;
        @(negedge iclk);
        bus.iDVAL = 1'b1;
        bus.iDATA = d;
        bus.iSOF  = sof;
        if (sof || !m_primed) begin
            mr = 0;
            mc = 0;
        end
        m_primed = 1;
        r = mr;
        c = mc;
        img[r][c] = d;
        if (r >= 1 && c >= 1) begin
            e.d   = exp_px(r - 1, c - 1);
            e.sof = (r == 1 && c == 1);
            e.eol = (c == W - 1);
            e.cyc = cyc + 1;
            sb.push_back(e);
        end
        if (c == W - 1) begin
            mc = 0;
            mr = (r == H - 1) ? 0 : r + 1;
        end else begin
            mc = c + 1;
        end
    endtask

    task automatic send_frame(input int pid, input bit sof_first, input bit gaps);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (gaps) idle($urandom_range(0, 1));
                send_px(pix(pid, r, c), sof_first && r == 0 && c == 0);
            end
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        idle(1);
        while (sb.size() != 0 && n < 20) begin
            @(negedge iclk);
            #1;
            n++;
        end
        idle(2);
        check(name, sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b_out, b_ones, b_sof, b_cap, e_cap, mism;
        irst = 1'b1;
        bus.iDATA = 1'b0;
        bus.iDVAL = 1'b0;
        bus.iSOF  = 1'b0;
        repeat (3) @(negedge iclk);
        check("reset_odata", int'(bus.oDATA), 0);
        check("reset_odval", int'(bus.oDVAL), 0);
        check("reset_osof",  int'(bus.oSOF), 0);
        check("reset_oeol",  int'(bus.oEOL), 0);
        irst = 1'b0;
        idle(2);

        // Single foreground pixel at (2,3), first frame without iSOF.
        b_out = n_out; b_ones = n_ones;
        send_frame(0, 0, 0);
        drain("drain_single");
        check("single_count", n_out - b_out, 35);
        check("single_ones", n_ones - b_ones, ONES_A);

        b_out = n_out; b_ones = n_ones;
        send_frame(1, 1, 0);
        drain("drain_ones");
        check("ones_count", n_out - b_out, 35);
        check("ones_ones", n_ones - b_ones, 35);

        // Only (0,0) set, right after an all-ones frame: border masking.
        b_out = n_out; b_ones = n_ones;
        send_frame(2, 1, 0);
        drain("drain_corner");
        check("corner_count", n_out - b_out, 35);
        check("corner_ones", n_ones - b_ones, ONES_C);

        // Same image with random gaps, then gap-free.
        b_out = n_out; b_cap = cap.size();
        send_frame(3, 1, 1);
        drain("drain_gaps");
        check("gaps_count", n_out - b_out, 35);
        e_cap = cap.size();
        send_frame(3, 1, 0);
        drain("drain_nogaps");
        check("nogaps_count", cap.size() - e_cap, 35);
        mism = 0;
        for (int i = 0; i < 35; i++) begin
            if (e_cap + i < cap.size() && cap[b_cap + i] !== cap[e_cap + i]) mism++;
        end
        check("gap_sequence", mism, 0);

        // iSOF re-asserted at (3,5), then a full frame.
        b_out = n_out; b_sof = n_sof;
        for (int r = 0; r <= 3; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r < 3 || c < 5) send_px(pix(3, r, c), r == 0 && c == 0);
            end
        end
        send_frame(3, 1, 0);
        drain("drain_restart");
        check("restart_count", n_out - b_out, 53);
        check("restart_sofs", n_sof - b_sof, 2);

        // Reset while the first output of a frame is on the bus.
        for (int c = 0; c < W; c++) send_px(c == 0, c == 0);
        send_px(1'b0, 1'b0);
        send_px(1'b0, 1'b0);
        @(posedge iclk);
        #1;
        check("prerst_odval", int'(bus.oDVAL), 1);
        check("prerst_odata", int'(bus.oDATA), 1);
        irst = 1'b1;
        #1;
        check("rst_odata", int'(bus.oDATA), 0);
        check("rst_odval", int'(bus.oDVAL), 0);
        check("rst_osof",  int'(bus.oSOF), 0);
        check("rst_oeol",  int'(bus.oEOL), 0);
        sb.delete();
        rst_cnt++;
        m_primed = 0;
        mr = 0;
        mc = 0;
        #1;
        irst = 1'b0;
        idle(2);

        b_out = n_out;
        send_frame(3, 0, 0);
        drain("drain_postrst");
        check("postrst_count", n_out - b_out, 35);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
